// File: rtl/ram_bist.sv
// March C- self-test engine that owns one RAM port while busy and checks read data
// through a LATENCY-deep compare pipeline. Define RAM_BIST_FAIL_LOG_EN to keep first-fail capture.
module ram_bist #(
    parameter int                WIDTH   = 32,
    parameter int                DEPTH   = 1024,
    parameter int                LATENCY = 1,
    parameter logic [WIDTH-1:0]  DATA_BG = {WIDTH{1'b0}},
    localparam int               AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      fail_cnt,
    output logic [AW-1:0]    fail_addr,
    output logic [WIDTH-1:0] fail_data,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W0_UP,
        S_R0W1_UP,
        S_R1W0_UP,
        S_R0W1_DN,
        S_R1W0_DN,
        S_R0_UP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0]    ADDR_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    ADDR_ONE   = AW'(1);
    localparam logic [1:0]       DRAIN_LAST = 2'(LATENCY - 1);
    localparam logic [WIDTH-1:0] BG0        = DATA_BG;
    localparam logic [WIDTH-1:0] BG1        = ~DATA_BG;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             wr_ph_q, wr_ph_d;
    logic [1:0]       drain_q, drain_d;

    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_din_q, mem_din_d;
    logic             rd_q, rd_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             pass_q, pass_d;
    logic [15:0]      fail_cnt_q, fail_cnt_d;

    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [WIDTH-1:0]   exp_pipe_q [LATENCY];
    logic [WIDTH-1:0]   exp_pipe_d [LATENCY];

    logic start_acc;
    logic miscmp;

    assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
    assign miscmp    = vld_pipe_q[LATENCY-1] && (mem_dout != exp_pipe_q[LATENCY-1]);

    // Sequencer: each element ends on its last address and the next element starts
    // on the following cycle; RW elements alternate a read phase and a write phase.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_ph_d = wr_ph_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_W0_UP;
                    addr_d  = '0;
                    wr_ph_d = 1'b0;
                end
            end
            S_W0_UP: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_R0W1_UP;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_R0W1_UP, S_R1W0_UP: begin
                if (!wr_ph_q) begin
                    wr_ph_d = 1'b1;
                end else begin
                    wr_ph_d = 1'b0;
                    if (addr_q == ADDR_LAST) begin
                        if (state_q == S_R0W1_UP) begin
                            state_d = S_R1W0_UP;
                            addr_d  = '0;
                        end else begin
                            state_d = S_R0W1_DN;
                            addr_d  = ADDR_LAST;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            S_R0W1_DN, S_R1W0_DN: begin
                if (!wr_ph_q) begin
                    wr_ph_d = 1'b1;
                end else begin
                    wr_ph_d = 1'b0;
                    if (addr_q == '0) begin
                        if (state_q == S_R0W1_DN) begin
                            state_d = S_R1W0_DN;
                            addr_d  = ADDR_LAST;
                        end else begin
                            state_d = S_R0_UP;
                            addr_d  = '0;
                        end
                    end else begin
                        addr_d = addr_q - ADDR_ONE;
                    end
                end
            end
            S_R0_UP: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port operation is decoded from the next state so it lands in flops together with it.
    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;
        rd_d       = 1'b0;
        exp_d      = '0;
        busy_d     = !(state_d == S_IDLE || state_d == S_DONE);
        done_d     = (state_d == S_DONE);
        unique case (state_d)
            S_W0_UP: begin
                mem_we_d   = 1'b1;
                mem_addr_d = addr_d;
                mem_din_d  = BG0;
            end
            S_R0W1_UP, S_R0W1_DN: begin
                mem_addr_d = addr_d;
                if (wr_ph_d) begin
                    mem_we_d  = 1'b1;
                    mem_din_d = BG1;
                end else begin
                    rd_d  = 1'b1;
                    exp_d = BG0;
                end
            end
            S_R1W0_UP, S_R1W0_DN: begin
                mem_addr_d = addr_d;
                if (wr_ph_d) begin
                    mem_we_d  = 1'b1;
                    mem_din_d = BG0;
                end else begin
                    rd_d  = 1'b1;
                    exp_d = BG1;
                end
            end
            S_R0_UP: begin
                mem_addr_d = addr_d;
                rd_d       = 1'b1;
                exp_d      = BG0;
            end
            default: ;
        endcase
    end

    // Compare pipeline: stage 0 follows the issued read by one cycle, which is
    // exactly when a 1-cycle RAM presents its data.
    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = rd_q;
        exp_pipe_d[0] = exp_q;
        for (int i = 1; i < LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            exp_pipe_d[i] = exp_pipe_q[i-1];
        end
    end

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        pass_d     = pass_q;
        if (start_acc) begin
            fail_cnt_d = '0;
            pass_d     = 1'b1;
        end else if (miscmp) begin
            pass_d = 1'b0;
            if (fail_cnt_q != 16'hFFFF) begin
                fail_cnt_d = fail_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wr_ph_q    <= 1'b0;
            drain_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rd_q       <= 1'b0;
            exp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b1;
            fail_cnt_q <= '0;
            vld_pipe_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                exp_pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_ph_q    <= wr_ph_d;
            drain_q    <= drain_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rd_q       <= rd_d;
            exp_q      <= exp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_cnt_q <= fail_cnt_d;
            vld_pipe_q <= vld_pipe_d;
            for (int i = 0; i < LATENCY; i++) begin
                exp_pipe_q[i] <= exp_pipe_d[i];
            end
        end
    end

`ifdef RAM_BIST_FAIL_LOG_EN
    logic [AW-1:0]    addr_pipe_q [LATENCY];
    logic [AW-1:0]    addr_pipe_d [LATENCY];
    logic [AW-1:0]    fail_addr_q, fail_addr_d;
    logic [WIDTH-1:0] fail_data_q, fail_data_d;

    // A zero count before this compare marks the first miscompare of the run.
    always_comb begin
        addr_pipe_d[0] = mem_addr_q;
        for (int i = 1; i < LATENCY; i++) begin
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (start_acc) begin
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (miscmp && fail_cnt_q == '0) begin
            fail_addr_d = addr_pipe_q[LATENCY-1];
            fail_data_d = mem_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            for (int i = 0; i < LATENCY; i++) begin
                addr_pipe_q[i] <= addr_pipe_d[i];
            end
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_cnt = fail_cnt_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: two instances (read latency 1 and 2) each beside a small RAM model
// with an optional stuck-at-1 fault on bit 0 of address 5.
module tb_ram_bist;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam logic [W-1:0] BG = 8'h55;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start1, start2;
  logic fault_en;

  logic          busy1, done1, pass1, mem_we1;
  logic [15:0]   fail_cnt1;
  logic [AW-1:0] fail_addr1, mem_addr1;
  logic [W-1:0]  fail_data1, mem_din1, mem_dout1;

  logic          busy2, done2, pass2, mem_we2;
  logic [15:0]   fail_cnt2;
  logic [AW-1:0] fail_addr2, mem_addr2;
  logic [W-1:0]  fail_data2, mem_din2, mem_dout2;

  ram_bist #(.WIDTH(W), .DEPTH(D), .LATENCY(1), .DATA_BG(BG)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_cnt(fail_cnt1), .fail_addr(fail_addr1), .fail_data(fail_data1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_dout(mem_dout1)
  );

  ram_bist #(.WIDTH(W), .DEPTH(D), .LATENCY(2), .DATA_BG(BG)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_cnt(fail_cnt2), .fail_addr(fail_addr2), .fail_data(fail_data2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_dout(mem_dout2)
  );

  // RAM models
  logic [W-1:0] ram1 [D];
  logic [W-1:0] ram2 [D];
  logic [W-1:0] ram2_stage;

  always @(posedge clk) begin
    if (mem_we1) ram1[mem_addr1] <= mem_din1;
    mem_dout1 <= ram1[mem_addr1] | ((fault_en && mem_addr1 == 4'd5) ? 8'h01 : 8'h00);
  end

  always @(posedge clk) begin
    if (mem_we2) ram2[mem_addr2] <= mem_din2;
    ram2_stage <= ram2[mem_addr2];
    mem_dout2  <= ram2_stage;
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [AW-1:0] addr_log[$];
  logic          we_log[$];

  logic          first_busy, first_done, first_we;
  logic [AW-1:0] first_addr;
  logic [W-1:0]  first_din;
  logic [15:0]   first_fcnt;
  int            cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver: pulse start on one instance, count busy cycles, optional second start at kick_at
  task automatic run_test(input int sel, input int kick_at, output int cycles);
    logic b;
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    first_busy = (sel == 1) ? busy1     : busy2;
    first_done = (sel == 1) ? done1     : done2;
    first_we   = (sel == 1) ? mem_we1   : mem_we2;
    first_addr = (sel == 1) ? mem_addr1 : mem_addr2;
    first_din  = (sel == 1) ? mem_din1  : mem_din2;
    first_fcnt = (sel == 1) ? fail_cnt1 : fail_cnt2;
    addr_log.delete();
    we_log.delete();
    cycles = 0;
    b = first_busy;
    while (b && cycles < 400) begin
      if (sel == 2) begin
        addr_log.push_back(mem_addr2);
        we_log.push_back(mem_we2);
      end
      if (cycles == kick_at) begin
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
      end
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      cycles++;
      b = (sel == 1) ? busy1 : busy2;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start1   = 1'b0;
    start2   = 1'b0;
    fault_en = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_busy",      busy1,      0);
    check("rst_done",      done1,      0);
    check("rst_pass",      pass1,      1);
    check("rst_fail_cnt",  fail_cnt1,  0);
    check("rst_fail_addr", fail_addr1, 0);
    check("rst_fail_data", fail_data1, 0);
    check("rst_mem_we",    mem_we1,    0);
    check("rst_mem_addr",  mem_addr1,  0);
    check("rst_mem_din",   mem_din1,   0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // fault-free, latency 1
    run_test(1, -1, cyc);
    check("t1_first_busy", first_busy, 1);
    check("t1_first_we",   first_we,   1);
    check("t1_first_addr", first_addr, 0);
    check("t1_first_din",  first_din,  8'h55);
    check("t1_busy_cycles", cyc, 161);
    check("t1_done",     done1,     1);
    check("t1_pass",     pass1,     1);
    check("t1_fail_cnt", fail_cnt1, 0);
    check("t1_idle_we",  mem_we1,   0);
    check("t1_idle_addr", mem_addr1, 0);

    // fault-free, latency 2, with address sequence
    run_test(2, -1, cyc);
    check("t2_busy_cycles", cyc, 162);
    check("t2_done", done2, 1);
    check("t2_pass", pass2, 1);
    check("t2_fail_cnt", fail_cnt2, 0);
    check("t2_log_len", addr_log.size(), 162);
    if (addr_log.size() == 162) begin
      check("t2_w0_addr0",    addr_log[0],   0);
      check("t2_w0_addr15",   addr_log[15],  15);
      check("t2_w0_we",       we_log[15],    1);
      check("t2_r0w1_rd_adr", addr_log[16],  0);
      check("t2_r0w1_rd_we",  we_log[16],    0);
      check("t2_r0w1_wr_adr", addr_log[17],  0);
      check("t2_r0w1_wr_we",  we_log[17],    1);
      check("t2_r0w1_last",   addr_log[47],  15);
      check("t2_r1w0_first",  addr_log[48],  0);
      check("t2_dn_first",    addr_log[80],  15);
      check("t2_dn_second",   addr_log[82],  14);
      check("t2_dn_last",     addr_log[111], 0);
      check("t2_dn2_first",   addr_log[112], 15);
      check("t2_dn2_last",    addr_log[143], 0);
      check("t2_r0_first",    addr_log[144], 0);
      check("t2_r0_we",       we_log[144],   0);
      check("t2_r0_last",     addr_log[159], 15);
      check("t2_drain_we",    we_log[160],   0);
    end

    // stuck-at-1 on bit 0 of address 5
    fault_en = 1'b1;
    run_test(1, -1, cyc);
    check("t3_busy_cycles", cyc, 161);
    check("t3_done",     done1,     1);
    check("t3_pass",     pass1,     0);
    check("t3_fail_cnt", fail_cnt1, 2);
`ifdef RAM_BIST_FAIL_LOG_EN
    check("t3_fail_addr", fail_addr1, 5);
    check("t3_fail_data", fail_data1, 8'hAB);
`else
    check("t3_fail_addr", fail_addr1, 0);
    check("t3_fail_data", fail_data1, 0);
`endif

    // start while done: fresh run, counters cleared
    fault_en = 1'b0;
    run_test(1, -1, cyc);
    check("t5b_done_clr",  first_done, 0);
    check("t5b_fcnt_clr",  first_fcnt, 0);
    check("t5b_busy",      first_busy, 1);
    check("t5b_busy_cycles", cyc, 161);
    check("t5b_pass",      pass1,     1);
    check("t5b_fail_cnt",  fail_cnt1, 0);

    // reset mid-test
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_busy_before", busy1, 1);
    rst_n = 1'b0;
    #1;
    check("t4_busy",      busy1,     0);
    check("t4_done",      done1,     0);
    check("t4_pass",      pass1,     1);
    check("t4_fail_cnt",  fail_cnt1, 0);
    check("t4_mem_we",    mem_we1,   0);
    check("t4_mem_addr",  mem_addr1, 0);
    check("t4_mem_din",   mem_din1,  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_test(1, -1, cyc);
    check("t4_rerun_cycles", cyc, 161);
    check("t4_rerun_pass", pass1, 1);
    check("t4_rerun_done", done1, 1);

    // start mid-run ignored
    run_test(1, 20, cyc);
    check("t5a_busy_cycles", cyc, 161);
    check("t5a_pass", pass1, 1);
    check("t5a_done", done1, 1);
    @(negedge clk);
    check("t5a_done_held", done1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
